rd_burst_sched: RTL and testbench

//  Read-side burst scheduler for the async FIFO, in the rclk domain. Computes occupancy

---
 rtl/rd_burst_sched.sv | 174 +++++++++++++++++
 tb/tb_rd_burst_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_sched.sv
// Read-side burst scheduler for the async FIFO (rclk domain): occupancy tracking, burst pop sequencing
// and a registered valid/ready output stream. Optional partial-burst timeout under `RD_TIMEOUT_EN.
module rd_burst_sched #(
   parameter int ADDRSIZE  = 4,
   parameter int DSIZE     = 8,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic                en,
   input  logic                flush,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   input  logic [ADDRSIZE:0]   rptr,
   input  logic                rempty,
   input  logic [DSIZE-1:0]    rdata,
   output logic                rinc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DSIZE-1:0]    out_data,
   output logic                out_last,
   output logic [ADDRSIZE:0]   level,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ADDRSIZE:0] ZERO_C      = {(ADDRSIZE+1){1'b0}};
   localparam logic [ADDRSIZE:0] ONE_C       = (ADDRSIZE+1)'(1);
   localparam logic [ADDRSIZE:0] BURST_LEN_C = (ADDRSIZE+1)'(BURST_LEN);

   if (BURST_LEN < 1 || BURST_LEN > 2**ADDRSIZE || TIMEOUT < 1) begin : g_param_check
      $error("rd_burst_sched: illegal BURST_LEN or TIMEOUT");
   end

   function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
      logic [ADDRSIZE:0] b;
      b[ADDRSIZE] = g[ADDRSIZE];
      for (int i = ADDRSIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   state_t              state_r, state_s;
   logic [ADDRSIZE:0]   rem_r, rem_s;
   logic [ADDRSIZE:0]   level_r;
   logic                out_valid_r, out_valid_s;
   logic [DSIZE-1:0]    out_data_r, out_data_s;
   logic                out_last_r, out_last_s;
   logic                busy_r, busy_s;
   logic                rinc_s;
   logic                accept_s;
   logic                timeout_hit_s;

   assign accept_s = out_valid_r && out_ready;

`ifdef RD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_r;

   assign timeout_hit_s = (timer_r == TW'(TIMEOUT));

   // Counts WAIT cycles holding a partial burst; any other situation restarts it.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         timer_r <= {TW{1'b0}};
      end else if (state_r == ST_WAIT && state_s == ST_WAIT &&
                   level_r != ZERO_C && level_r < BURST_LEN_C) begin
         timer_r <= timer_r + TW'(1);
      end else begin
         timer_r <= {TW{1'b0}};
      end
   end
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Next-state, pop strobe and output-register next values.
   always_comb begin
      state_s     = state_r;
      rem_s       = rem_r;
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      out_last_s  = out_last_r;
      rinc_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!en) begin
               state_s = ST_IDLE;
            end else if (level_r >= BURST_LEN_C ||
                         ((flush || timeout_hit_s) && level_r != ZERO_C)) begin
               state_s = ST_BURST;
               rem_s   = (level_r >= BURST_LEN_C) ? BURST_LEN_C : level_r;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_BURST: begin
            // rempty is the final guard: a stale level must never cause a pop of an empty FIFO.
            rinc_s = !rempty && rem_r != ZERO_C && (!out_valid_r || out_ready);
            if (rinc_s) begin
               out_data_s  = rdata;
               out_valid_s = 1'b1;
               rem_s       = rem_r - ONE_C;
               out_last_s  = (rem_r == ONE_C);
               if (rem_r == ONE_C) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_BURST;
               end
            end else if (accept_s) begin
               out_valid_s = 1'b0;
            end else begin
               out_valid_s = out_valid_r;
            end
         end
         ST_DONE: begin
            if (accept_s && out_last_r) begin
               out_valid_s = 1'b0;
               state_s     = en ? ST_WAIT : ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
         end
      endcase
      busy_s = (state_s == ST_BURST) || (state_s == ST_DONE);
   end

   // State, burst counter, occupancy and output registers.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_r     <= ST_IDLE;
         rem_r       <= ZERO_C;
         level_r     <= ZERO_C;
         out_valid_r <= 1'b0;
         out_data_r  <= {DSIZE{1'b0}};
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         rem_r       <= rem_s;
         level_r     <= gray2bin(rq2_wptr) - gray2bin(rptr);
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         out_last_r  <= out_last_s;
         busy_r      <= busy_s;
      end
   end

   assign rinc      = rinc_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign level     = level_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_rd_burst_sched.sv
// Scoreboard bench for rd_burst_sched: a small FIFO read-side model feeds the DUT, a monitor
// pops expected {last,data} words as they are accepted. Set RD_TIMEOUT_EN to exercise the timer build.
module tb_rd_burst_sched;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          rclk = 1'b0;
   logic          rrst_n = 1'b1;
   logic          en = 1'b0;
   logic          flush = 1'b0;
   logic          out_ready = 1'b0;
   logic [AW:0]   rq2_wptr, rptr, level;
   logic          rempty, rinc, out_valid, out_last, busy;
   logic [DW-1:0] rdata, out_data;

   logic [DW-1:0] mem [0:15];
   logic [AW:0]   wbin = '0;
   logic [AW:0]   rbin, rbin_nx;
   logic [AW:0]   rbin_init = '0;
   logic          rempty_r;
   logic [DW:0]   exp_q [$];

   int n_checks = 0;
   int n_pass   = 0;
   int pop_cnt  = 0;
   int run_len  = 0;
   int run_max  = 0;
   int base     = 0;

   rd_burst_sched #(.ADDRSIZE(AW), .DSIZE(DW), .BURST_LEN(4), .TIMEOUT(8)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .en(en), .flush(flush),
      .rq2_wptr(rq2_wptr), .rptr(rptr), .rempty(rempty), .rdata(rdata),
      .rinc(rinc), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .level(level), .busy(busy)
   );

   always #5 rclk = ~rclk;

   // FIFO read side: binary read pointer, Gray views, registered empty flag.
   assign rq2_wptr = wbin ^ (wbin >> 1);
   assign rptr     = rbin ^ (rbin >> 1);
   assign rempty   = rempty_r;
   assign rdata    = mem[rbin[AW-1:0]];
   assign rbin_nx  = rbin + {{AW{1'b0}}, (rinc & ~rempty_r)};

   always @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin     <= rbin_init;
         rempty_r <= 1'b1;
      end else begin
         rbin     <= rbin_nx;
         rempty_r <= ((rbin_nx ^ (rbin_nx >> 1)) == rq2_wptr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge rclk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d, input logic last, input logic push);
      mem[wbin[AW-1:0]] = d;
      wbin = wbin + 5'd1;
      if (push) exp_q.push_back({last, d});
   endtask

   task automatic wait_pops(input int target, input int budget);
      for (int i = 0; i < budget && pop_cnt < target; i++) @(posedge rclk);
      if (pop_cnt < target) chk("wait_pops_timeout", 32'(pop_cnt), 32'(target));
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge rclk);
         if (exp_q.size() == 0 && !busy) break;
      end
      if (i == budget) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge rclk);
      #1;
   endtask

   // Monitor: compare accepted words, hold stability under stall, count pops.
   initial begin
      logic          prev_stall;
      logic [DW:0]   prev_word;
      logic [DW:0]   exp_w;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge rclk);
         if (!rrst_n) begin
            prev_stall = 1'b0;
            run_len    = 0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_word", 32'({out_last, out_data}), 32'(prev_word));
            end
            if (rinc) begin
               pop_cnt++;
               run_len++;
               if (run_len > run_max) run_max = run_len;
            end else begin
               run_len = 0;
            end
            if (out_valid && !out_ready) chk("no_pop_stalled", 32'(rinc), 32'd0);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_word: got %0h expected none", {out_last, out_data});
               end else begin
                  exp_w = exp_q.pop_front();
                  chk("out_word", 32'({out_last, out_data}), 32'(exp_w));
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      // Reset state
      #1 rrst_n = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rinc", 32'(rinc), 32'd0);
      cyc(2);
      rrst_n = 1'b1;
      cyc(1);

      // Full burst of 4 at full rate
      en = 1'b1; out_ready = 1'b1;
      cyc(2);
      base = pop_cnt; run_max = 0;
      for (int i = 0; i < 4; i++) write_word(8'hA0 + 8'(i), (i == 3), 1'b1);
      wait_drain(40);
      chk("t2_pops", 32'(pop_cnt - base), 32'd4);
      chk("t2_run", 32'(run_max), 32'd4);
      chk("t2_busy", 32'(busy), 32'd0);

      // Stall for 3 cycles after the first word
      base = pop_cnt;
      for (int i = 0; i < 4; i++) write_word(8'hB0 + 8'(i), (i == 3), 1'b1);
      wait_pops(base + 1, 20);
      out_ready = 1'b0;
      cyc(3);
      out_ready = 1'b1;
      wait_drain(40);
      chk("t3_pops", 32'(pop_cnt - base), 32'd4);

      // Partial burst: flush on empty is ignored, then 3 words wait for flush or timeout
      chk("t4_level0", 32'(level), 32'd0);
      flush = 1'b1; cyc(1); flush = 1'b0;
      cyc(2);
      base = pop_cnt;
      for (int i = 0; i < 3; i++) write_word(8'hC0 + 8'(i), (i == 2), 1'b1);
      cyc(20);
`ifdef RD_TIMEOUT_EN
      chk("t4_timeout_pops", 32'(pop_cnt - base), 32'd3);
      wait_drain(40);
`else
      chk("t4_no_pop", 32'(pop_cnt - base), 32'd0);
      chk("t4_level", 32'(level), 32'd3);
      chk("t4_busy_idle", 32'(busy), 32'd0);
      flush = 1'b1; cyc(1); flush = 1'b0;
      wait_drain(40);
      chk("t4_flush_pops", 32'(pop_cnt - base), 32'd3);
`endif

      // en dropped mid-burst: burst still completes
      base = pop_cnt;
      for (int i = 0; i < 4; i++) write_word(8'hD0 + 8'(i), (i == 3), 1'b1);
      wait_pops(base + 2, 20);
      en = 1'b0;
      wait_drain(40);
      chk("t6_pops", 32'(pop_cnt - base), 32'd4);
      cyc(3);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_quiet", 32'(pop_cnt - base), 32'd4);

      // Reset mid-burst with a stalled word in the output register
      en = 1'b1; out_ready = 1'b0;
      cyc(2);
      base = pop_cnt;
      for (int i = 0; i < 4; i++) write_word(8'hE0 + 8'(i), 1'b0, 1'b0);
      wait_pops(base + 1, 20);
      cyc(1);
      chk("t1_busy_before", 32'(busy), 32'd1);
      #2 rrst_n = 1'b0;
      #1;
      chk("t1_out_valid", 32'(out_valid), 32'd0);
      chk("t1_level", 32'(level), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_rinc", 32'(rinc), 32'd0);
      exp_q.delete();

      // Pointer wrap: rptr at 30, four words take wptr to 2
      en = 1'b0; out_ready = 1'b1;
      rbin_init = 5'd30;
      wbin = 5'd30;
      cyc(2);
      for (int i = 0; i < 4; i++) write_word(8'hF0 + 8'(i), (i == 3), 1'b1);
      rrst_n = 1'b1;
      cyc(3);
      chk("t5_level", 32'(level), 32'd4);
      base = pop_cnt;
      en = 1'b1;
      wait_drain(40);
      chk("t5_pops", 32'(pop_cnt - base), 32'd4);
      chk("t5_rbin", 32'(rbin), 32'd2);
      chk("t5_rempty", 32'(rempty), 32'd1);
      chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
